stream_unpacker: RTL
====================

STREAM_UNPACKER -- requirements
Module: stream_unpacker

Interface
REQ-001 SHALL have parameter word_size, default 32: width of words read from the upstream circular buffer.
REQ-002 SHALL have parameter out_size, default 8: width of each output slice; word_size SHALL be an integer multiple of out_size, with ratio N = word_size/out_size >= 2.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port empty, input, 1: upstream buffer holds no words.
REQ-006 SHALL have port rd, output, 1: read strobe to upstream; each cycle high pops one word.
REQ-007 SHALL have port data_in, input, word_size: upstream word, valid the cycle after rd was high.
REQ-008 SHALL have port out_data, output, out_size: current slice.
REQ-009 SHALL have port out_valid, output, 1: out_data holds a slice.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts the slice this cycle.
REQ-011 SHALL have port word_count, output, 16: number of fully emitted words, modulo 2^16.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, SEND; out_valid SHALL be high exactly in SEND.
REQ-013 In IDLE: rd SHALL be high combinationally when empty=0, and the next state SHALL be WAIT; otherwise the FSM SHALL stay in IDLE.
REQ-014 In WAIT: at the cycle end, data_in SHALL be captured into a word_size shift register, the slice index SHALL be set to 0, and the next state SHALL be SEND; rd SHALL be low.
REQ-015 In SEND: out_data SHALL be the slice selected by the index (see REQ-023); without out_ready, out_data and the index SHALL hold stable.
REQ-016 In SEND, if out_ready=1 and index < N-1: the index SHALL increment, and the state SHALL remain SEND.
REQ-017 In SEND, if out_ready=1 and index = N-1: word_count SHALL increment; if empty=0, rd SHALL be high that same cycle and the next state SHALL be WAIT; otherwise the next state SHALL be IDLE.
REQ-018 rd SHALL never be high when empty=1, in WAIT, or while rst=1.
REQ-019 Latency: empty falling in IDLE at cycle t SHALL give first out_valid at cycle t+2.
REQ-020 Throughput: with out_ready held high and a non-empty upstream, the block SHALL emit N slices per N+1 cycles.
REQ-021 word_count SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-022 While rst=1 at a clock edge: state SHALL be IDLE, out_valid=0, out_data=0, index=0, shift register=0, word_count=0, and rd SHALL be 0. rst SHALL take priority over every other event, including mid-word: a partially emitted word SHALL be discarded, and a pending WAIT capture SHALL be dropped.

Configuration
REQ-023 Macro UNPACKER_MSB_FIRST_EN: when defined, slice index i SHALL map to bits [word_size-1-i*out_size -: out_size], i.e. MSB slice first; when undefined, index i SHALL map to bits [i*out_size +: out_size], i.e. LSB slice first. No other behaviour SHALL differ.

Verification
REQ-024 Macro undefined, word 0xA1B2C3D4 in the buffer, out_ready=1 -> out_data sequence D4,C3,B2,A1 on 4 consecutive cycles starting 2 cycles after empty falls; word_count=1; the FSM returns to IDLE.
REQ-025 Macro defined, same stimulus -> out_data sequence A1,B2,C3,D4.
REQ-026 Words 0x11223344 and 0x55667788 queued, out_ready=1 -> rd high in the same cycle the 4th slice of the first word is accepted; exactly one bubble cycle between words; word_count=2.
REQ-027 out_ready low for 3 cycles while slice 1 is presented -> out_data and out_valid stay stable those 3 cycles; no rd issued; no slice lost or duplicated.
REQ-028 rst asserted after 2 of 4 slices are accepted -> next cycle out_valid=0, word_count=0, rd=0 while rst is high; after release with empty=1 the FSM stays in IDLE.
REQ-029 word_count preloaded via 65535 emitted words, one more word emitted -> word_count reads 0x0000.

Source files
------------

// File: rtl/stream_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : stream_unpacker
//  Description : Pops words from an upstream circular buffer and emits them
//                as word_size/out_size narrower slices on a ready/valid
//                stream. Counts fully emitted words (16-bit, wrapping).
//                Compile-time option UNPACKER_MSB_FIRST_EN selects
//                MSB-slice-first ordering; the default is LSB-slice-first.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_unpacker #(
    parameter int word_size = 32,
    parameter int out_size  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 empty,
    output logic                 rd,
    input  logic [word_size-1:0] data_in,
    output logic [out_size-1:0]  out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          word_count
);

    localparam int                 c_N        = word_size / out_size;
    localparam int                 c_IDX_W    = $clog2(c_N);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_N - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_SEND = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [word_size-1:0] r_shift;
    logic [word_size-1:0] w_shifted;
    logic [c_IDX_W-1:0]   r_idx;
    logic [15:0]          r_word_count;
    logic                 w_accept;
    logic                 w_last;

    // The current slice always sits at the output end of the shift register,
    // so advancing to the next slice is a fixed shift rather than a wide mux.
`ifdef UNPACKER_MSB_FIRST_EN
    assign out_data  = r_shift[word_size-1 -: out_size];
    assign w_shifted = r_shift << out_size;
`else
    assign out_data  = r_shift[out_size-1:0];
    assign w_shifted = r_shift >> out_size;
`endif

    assign w_last     = (r_idx == c_LAST_IDX);
    assign out_valid  = (r_state == c_ST_SEND);
    assign word_count = r_word_count;

    // Next-state and read-strobe decode; rd is forced low during reset.
    always_comb begin
        w_next_state = r_state;
        rd           = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!empty) begin
                    rd           = 1'b1;
                    w_next_state = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                w_next_state = c_ST_SEND;
            end
            c_ST_SEND: begin
                if (out_ready) begin
                    w_accept = 1'b1;
                    if (w_last) begin
                        // Prefetch the next word while the last slice goes out
                        // so only one bubble cycle separates words.
                        if (!empty) begin
                            rd           = 1'b1;
                            w_next_state = c_ST_WAIT;
                        end else begin
                            w_next_state = c_ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
        if (rst) begin
            rd = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Word capture in WAIT and slice advance on each accepted slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (r_state == c_ST_WAIT) begin
            r_shift <= data_in;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_shift <= w_shifted;
            if (!w_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Completed-word counter, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_count <= '0;
        end else if (w_accept && w_last) begin
            r_word_count <= r_word_count + 16'd1;
        end
    end

endmodule
`default_nettype wire
